// File: rtl/gates_bist_pkg.sv
// Shared types and golden model for the two-input gate block self-test.
package gates_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_XOR  = 2;
  localparam int GATE_XNOR = 3;

  // Golden response of the gate block to stimulus {A,B} = vec.
  function automatic logic [3:0] gate_expected(input logic [1:0] vec);
    logic a;
    logic b;
    logic [3:0] r;
    a = vec[1];
    b = vec[0];
    r[GATE_AND]  = a & b;
    r[GATE_OR]   = a | b;
    r[GATE_XOR]  = a ^ b;
    r[GATE_XNOR] = ~(a ^ b);
    return r;
  endfunction

endpackage

// File: rtl/gates_bist.sv
// BIST sequencer: sweeps {A,B} through 00..11, compares the returned gate
// outputs with the golden model and reports sticky per-gate/per-vector faults.
module gates_bist
  import gates_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       A,
  output logic       B,
  input  logic       and_i,
  input  logic       or_i,
  input  logic       xor_i,
  input  logic       xnor_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] vec;
  logic [3:0] cnt;
  logic [3:0] gate_resp;
  logic [3:0] mism;
  logic [3:0] mask_next;

  // NOTE: combinational helpers assign every output unconditionally, so no latch can be inferred.
  always_comb begin
    gate_resp = 4'b0000;
    gate_resp[GATE_AND]  = and_i;
    gate_resp[GATE_OR]   = or_i;
    gate_resp[GATE_XOR]  = xor_i;
    gate_resp[GATE_XNOR] = xnor_i;
    mism      = gate_resp ^ gate_expected(vec);
    mask_next = fail_mask | mism;
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vec       <= 2'd0;
      cnt       <= 4'd0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'd0;
      fail_vec  <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pass      <= 1'b0;
            fail_mask <= 4'd0;
            fail_vec  <= 4'd0;
            vec       <= 2'd0;
            cnt       <= 4'd0;
            A         <= 1'b0;
            B         <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            A     <= 1'b0;
            B     <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
            if (cnt == SETTLE_LAST) state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          // An aborted sample is discarded; partial results from earlier vectors stay.
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            A     <= 1'b0;
            B     <= 1'b0;
          end else begin
            fail_mask <= mask_next;
            if (|mism) fail_vec[vec] <= 1'b1;
            if (vec == 2'd3) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mask_next == 4'd0);
              A     <= 1'b0;
              B     <= 1'b0;
            end else begin
              vec      <= vec + 2'd1;
              {A, B}   <= vec + 2'd1;
              cnt      <= 4'd0;
              state    <= ST_SETTLE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gates_bist.sv
// Directed bench for gates_bist wired to a behavioural gate block with a fault shim.
module tb_gates_bist;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       A;
  logic       B;
  logic       and_i;
  logic       or_i;
  logic       xor_i;
  logic       xnor_i;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;
  logic [3:0] fail_vec;

  // 0: fault-free, 1: AND stuck-at-1, 2: XOR/XNOR swapped
  int fault;

  int n_vec;
  int n_err;

  assign and_i  = (fault == 1) ? 1'b1 : (A & B);
  assign or_i   = A | B;
  assign xor_i  = (fault == 2) ? ~(A ^ B) : (A ^ B);
  assign xnor_i = (fault == 2) ? (A ^ B) : ~(A ^ B);

  gates_bist #(.SETTLE_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .A         (A),
    .B         (B),
    .and_i     (and_i),
    .or_i      (or_i),
    .xor_i     (xor_i),
    .xnor_i    (xnor_i),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask),
    .fail_vec  (fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ab"},   {2'b00, A, B}, 4'b0000);
    check({tag, "_busy"}, {3'b000, busy}, 4'b0000);
    check({tag, "_done"}, {3'b000, done}, 4'b0000);
  endtask

  // Full sweep with start sampled at edge 0; cycle c is the interval ending at edge c.
  task automatic run_sweep(input string tag, input logic exp_pass,
                           input logic [3:0] exp_mask, input logic [3:0] exp_fvec,
                           input bit extra_start);
    int dones;
    dones = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c <= 12) check({tag, "_ab"}, {2'b00, A, B}, 4'((c - 1) / 3));
      else         check({tag, "_ab"}, {2'b00, A, B}, 4'b0000);
      check({tag, "_busy"}, {3'b000, busy}, {3'b000, c <= 12});
      check({tag, "_done"}, {3'b000, done}, {3'b000, c == 13});
      if (done) dones++;
      if (c == 13) begin
        check({tag, "_pass"}, {3'b000, pass}, {3'b000, exp_pass});
        check({tag, "_mask"}, fail_mask, exp_mask);
        check({tag, "_fvec"}, fail_vec, exp_fvec);
      end
      start = extra_start && (c == 5 || c == 13);
      tick();
    end
    start = 1'b0;
    check({tag, "_busy_after"}, {3'b000, busy}, 4'b0000);
    check({tag, "_done_after"}, {3'b000, done}, 4'b0000);
    check({tag, "_done_count"}, 4'(dones), 4'd1);
    check({tag, "_mask_held"}, fail_mask, exp_mask);
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    fault = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset_pass", {3'b000, pass}, 4'b0000);
    check("reset_mask", fail_mask, 4'b0000);
    check("reset_fvec", fail_vec, 4'b0000);
    rst_n = 1'b1;
    tick();

    fault = 0;
    run_sweep("clean", 1'b1, 4'b0000, 4'b0000, 1'b0);

    fault = 1;
    run_sweep("and_sa1", 1'b0, 4'b0001, 4'b0111, 1'b0);

    fault = 2;
    run_sweep("xor_swap", 1'b0, 4'b1100, 4'b1111, 1'b0);

    fault = 0;
    run_sweep("start_ign", 1'b1, 4'b0000, 4'b0000, 1'b1);

    // Abort during the vector-1 sample; that sample's AND mismatch must be dropped.
    fault = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    check("abort_pre_busy", {3'b000, busy}, 4'b0001);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle_outputs("abort");
    check("abort_pass", {3'b000, pass}, 4'b0000);
    check("abort_mask", fail_mask, 4'b0001);
    check("abort_fvec", fail_vec, 4'b0001);
    for (int c = 0; c < 10; c++) begin
      check("abort_no_done", {3'b000, done}, 4'b0000);
      tick();
    end

    // Asynchronous reset in the middle of cycle 7 of a faulty sweep.
    fault = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) tick();
    check("prerst_mask", fail_mask, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_pass", {3'b000, pass}, 4'b0000);
    check("async_rst_mask", fail_mask, 4'b0000);
    check("async_rst_fvec", fail_vec, 4'b0000);
    #2;
    rst_n = 1'b1;
    tick();
    check("post_rst_done", {3'b000, done}, 4'b0000);
    fault = 0;
    run_sweep("post_rst", 1'b1, 4'b0000, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gates_bist.md
# gates_bist

Built-in self-test sequencer for the basic two-input gate block: drives its `A`/`B` inputs through all four combinations, samples its AND/OR/XOR/XNOR outputs, and compares them against a golden model. The block sits beside the gate block on the same clock, under a start/done handshake. It reports an overall pass flag, a per-gate fault mask and a per-vector fault mask, all held until the next run.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling. Legal range is 1..15.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  sweep request; accepted only in IDLE.
- `abort`  in  1  synchronous cancel of a running sweep.
- `A`  out  1  stimulus to the gate block; registered.
- `B`  out  1  stimulus to the gate block; registered.
- `and_i`  in  1  AND output returned from the gate block.
- `or_i`  in  1  OR output returned from the gate block.
- `xor_i`  in  1  XOR output returned from the gate block.
- `xnor_i`  in  1  XNOR output returned from the gate block.
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  1 only if the last completed sweep had no mismatches.
- `fail_mask`  out  4  sticky per-gate mismatch flags: [0]=AND, [1]=OR, [2]=XOR, [3]=XNOR.
- `fail_vec`  out  4  sticky per-vector mismatch flags, indexed by {A,B}.

## Operation
- Reset: state=IDLE and every output is 0. This covers `A`, `B`, `busy`, `done`, `pass`, `fail_mask` and `fail_vec`.
- Internal registers:
  - 2-bit vector index `vec`.
  - 4-bit settle counter `cnt`.
  - `A`=`vec[1]`, `B`=`vec[0]`; both are 0 in IDLE.
- States:
  - **IDLE**: when `start`=1, clear `pass`, `fail_mask` and `fail_vec`, set vec=0 and cnt=0, then go to SETTLE.
  - **SETTLE**: increment cnt. When cnt==SETTLE_CYCLES-1, go to SAMPLE.
  - **SAMPLE** (one cycle):
    - Expected values: {xnor,xor,or,and} = {~(A^B), A^B, A|B, A&B}.
    - For each mismatching gate g, set `fail_mask[g]`. If any gate mismatches, set `fail_vec[vec]`.
    - If vec==3, go to DONE. Otherwise increment vec, set cnt=0, and return to SETTLE.
  - **DONE** (one cycle): `done`=1, `pass` = (`fail_mask`==0), `A`=`B`=0, then go to IDLE.
- `start` is ignored in SETTLE, SAMPLE and DONE.
- `abort` in SETTLE or SAMPLE:
  - Next state is IDLE; `A`=`B`=0; no `done` pulse; `pass` stays 0.
  - `fail_mask` and `fail_vec` keep their partial results.
  - A mismatch detected in the abort cycle itself is discarded.
- `abort` in IDLE or DONE has no effect.
- `abort` and `start` together in IDLE: `start` wins.
- `rst_n` assertion mid-sweep forces every output to 0 immediately, with no `done` pulse.
- Returned gate outputs are sampled raw; they are the gate block's combinational response to registered `A`/`B`.

## Timing
- `start` sampled at edge t: `busy`=1 from cycle t+1, and vector 0 is driven from t+1.
- Vector k is driven for SETTLE_CYCLES+1 cycles and compared at cycle t+(k+1)(SETTLE_CYCLES+1).
- `done` fires at t+4(SETTLE_CYCLES+1)+1. With the default SETTLE_CYCLES=2, that is t+13.
- `pass`, `fail_mask` and `fail_vec` are valid in the `done` cycle and held until the next accepted `start`.
- Earliest next `start` is accepted in the cycle after `done`.

## Structure
- Package `gates_bist_pkg` holds:
  - The state enum (IDLE, SETTLE, SAMPLE, DONE).
  - Gate-index localparams (GATE_AND=0, GATE_OR=1, GATE_XOR=2, GATE_XNOR=3).
  - Function `gate_expected(vec)` returning the 4-bit golden response.
- No sub-module: FSM, counter and comparator live in one module.
- The bench instantiates `gates_bist` wired to the real gate block. For fault-injection tests, it inserts a fault shim on the returned outputs.

## Test plan
1. **Fault-free**, SETTLE_CYCLES=2, `start` at cycle 0:
   - `A`/`B` step 00, 01, 10, 11, three cycles each.
   - `done` at cycle 13; `pass`=1, `fail_mask`=0000, `fail_vec`=0000.
2. **AND stuck-at-1**: `pass`=0, `fail_mask`=0001, `fail_vec`=0111.
3. **XOR/XNOR swapped**: `fail_mask`=1100, `fail_vec`=1111, `pass`=0.
4. **`start` ignored outside IDLE**: `start` at cycles 5 and 13 (the `done` cycle) is ignored. Exactly one `done` pulse occurs (cycle 13), and `busy`=0 at cycle 14.
5. **`abort` at cycle 6 with AND stuck-at-1** (vector 00 already compared at cycle 3):
   - At cycle 7: `busy`=0, `A`=`B`=0.
   - No `done` pulse; `pass`=0, `fail_mask`=0001, `fail_vec`=0001.
6. **Asynchronous reset**: `rst_n` low mid-cycle 7 drives all outputs to 0 at once. After release, `start` runs a full sweep with `done` 13 cycles later.
